moving_average_controller: RTL and testbench

//  Sequencer for the moving-average filter bank (windows 2/4/8/16). Generates the sample strobe into the bank,

---
 rtl/moving_average_pkg.sv | 22 ++
 rtl/moving_average_strobe_div.sv | 42 ++++
 rtl/moving_average_controller.sv | 99 +++++++++
 tb/tb_moving_average_controller.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared constants and helpers for the moving-average sequencer
package moving_average_pkg;

  localparam int DATA_W_DEF    = 10;
  localparam int DIV_W_DEF     = 8;
  localparam int MAX_POWER_DEF = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_WARMUP = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

  // Window length for a select code: 2, 4, 8 or 16 samples.
  function automatic logic [MAX_POWER_DEF:0] win_len(input logic [1:0] sel);
    logic [MAX_POWER_DEF:0] one;
    logic [2:0]             shamt;
    one   = 1;
    shamt = {1'b0, sel} + 3'd1;
    return one << shamt;
  endfunction

endpackage

// File: rtl/moving_average_strobe_div.sv
// rtl/moving_average_strobe_div.sv - sample strobe source: delayed external strobe or programmable divider
module moving_average_strobe_div
  import moving_average_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gen_en,
  input  logic             mode_i,
  input  logic             strobe_ext_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             filt_strobe_o
);

  logic [DIV_W-1:0] div_cnt;
  logic             mode_q;

  // A mode switch spends one cycle clearing the counter before the new source drives the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      mode_q        <= 1'b0;
      filt_strobe_o <= 1'b0;
    end else begin
      mode_q        <= mode_i;
      filt_strobe_o <= 1'b0;
      if (!gen_en || (mode_i != mode_q)) begin
        div_cnt <= '0;
      end else if (!mode_i) begin
        filt_strobe_o <= strobe_ext_i;
        div_cnt       <= '0;
      end else if (div_cnt >= div_i) begin
        filt_strobe_o <= 1'b1;
        div_cnt       <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/moving_average_controller.sv
// rtl/moving_average_controller.sv - filter-bank sequencer: select commit, flush, warm-up gating, output register
module moving_average_controller
  import moving_average_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int MAX_POWER = MAX_POWER_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              mode_i,
  input  logic              strobe_ext_i,
  input  logic [DIV_W-1:0]  div_i,
  input  logic [1:0]        sel_i,
  input  logic              ret_strobe_i,
  input  logic [DATA_W-1:0] ret_data_i,
  output logic              filt_strobe_o,
  output logic              flush_o,
  output logic [1:0]        sel_o,
  output logic              warm_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [1:0]           state;
  logic [MAX_POWER:0]   warm_cnt;
  logic [MAX_POWER:0]   warm_nxt;
  logic                 active;
  logic                 sel_chg;
  logic                 gen_en;

  assign active   = (state == ST_WARMUP) || (state == ST_RUN);
  assign sel_chg  = active && (sel_i != sel_o);
  assign gen_en   = ena && active && !sel_chg;
  assign flush_o  = (state == ST_FLUSH);
  assign warm_o   = (state == ST_WARMUP);
  assign warm_nxt = warm_cnt + (MAX_POWER+1)'(1);

  moving_average_strobe_div #(
    .DIV_W (DIV_W)
  ) u_strobe_div (
    .clk           (clk),
    .rst_n         (rst_n),
    .gen_en        (gen_en),
    .mode_i        (mode_i),
    .strobe_ext_i  (strobe_ext_i),
    .div_i         (div_i),
    .filt_strobe_o (filt_strobe_o)
  );

  // Priority: disable, then select change, then returned sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      sel_o    <= 2'd0;
      warm_cnt <= '0;
      valid_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      valid_o <= 1'b0;
      if (!ena) begin
        state    <= ST_IDLE;
        warm_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_FLUSH;
            sel_o <= sel_i;
          end
          ST_FLUSH: begin
            warm_cnt <= '0;
            state    <= ST_WARMUP;
          end
          ST_WARMUP: begin
            if (sel_chg) begin
              state <= ST_FLUSH;
              sel_o <= sel_i;
            end else if (ret_strobe_i) begin
              warm_cnt <= warm_nxt;
              if (warm_nxt == win_len(sel_o)) state <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (sel_chg) begin
              state <= ST_FLUSH;
              sel_o <= sel_i;
            end else if (ret_strobe_i) begin
              valid_o <= 1'b1;
              data_o  <= ret_data_i;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_average_controller.sv
// tb/tb_moving_average_controller.sv - directed self-checking bench for moving_average_controller
module tb_moving_average_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       mode = 1'b0;
  logic       strobe_ext = 1'b0;
  logic [7:0] div = 8'd0;
  logic [1:0] sel = 2'd0;
  logic       ret_strobe = 1'b0;
  logic [9:0] ret_data = 10'd0;
  logic       filt_strobe, flush, warm, valid;
  logic [1:0] sel_q;
  logic [9:0] data;

  int n_vec = 0;
  int n_bad = 0;
  logic seen;

  moving_average_controller dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .mode_i        (mode),
    .strobe_ext_i  (strobe_ext),
    .div_i         (div),
    .sel_i         (sel),
    .ret_strobe_i  (ret_strobe),
    .ret_data_i    (ret_data),
    .filt_strobe_o (filt_strobe),
    .flush_o       (flush),
    .sel_o         (sel_q),
    .warm_o        (warm),
    .valid_o       (valid),
    .data_o        (data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [9:0] d);
    ret_strobe = 1'b1;
    ret_data   = d;
    tick();
    ret_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_filt", filt_strobe, 0); chk("rst_flush", flush, 0);
    chk("rst_warm", warm, 0);        chk("rst_valid", valid, 0);
    chk("rst_sel", sel_q, 0);        chk("rst_data", data, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_flush", flush, 0);

    // Divider mode, period 4, window 2
    mode = 1'b1; div = 8'd3; sel = 2'd0; ena = 1'b1;
    tick();
    chk("t1_flush", flush, 1); chk("t1_flush_filt", filt_strobe, 0);
    tick();
    chk("t1_flush_once", flush, 0); chk("t1_warm", warm, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_div4", filt_strobe, (i % 4 == 3));
    end
    ret(10'h001); chk("t1_drop1", valid, 0); chk("t1_warm1", warm, 1);
    ret(10'h002); chk("t1_drop2", valid, 0); chk("t1_run", warm, 0);
    ret(10'h155); chk("t1_valid", valid, 1); chk("t1_data", data, 10'h155);
    tick();       chk("t1_valid_1cyc", valid, 0); chk("t1_data_hold", data, 10'h155);

    // Window 16 select change from RUN
    sel = 2'd3;
    tick(); chk("t2_flush", flush, 1); chk("t2_sel", sel_q, 3);
    tick(); chk("t2_flush_once", flush, 0); chk("t2_warm", warm, 1);
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      ret(10'(i + 16)); seen = seen | valid;
    end
    chk("t2_dropped16", seen, 0); chk("t2_run", warm, 0);
    ret(10'h2AA); chk("t2_valid", valid, 1); chk("t2_data", data, 10'h2AA);

    // Divider reprogramming
    ena = 1'b0;
    tick();
    chk("t3_off_flush", flush, 0); chk("t3_off_warm", warm, 0);
    chk("t3_off_filt", filt_strobe, 0); chk("t3_off_valid", valid, 0);
    div = 8'd9; ena = 1'b1;
    tick(); chk("t3_flush", flush, 1);
    tick(); chk("t3_warm", warm, 1);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("t3_div9_quiet", filt_strobe, 0);
    end
    div = 8'd2;
    tick(); chk("t3_lowered_pulse", filt_strobe, 1);
    for (int i = 0; i < 6; i++) begin
      tick(); chk("t3_div3", filt_strobe, (i % 3 == 2));
    end
    div = 8'd0;
    for (int i = 0; i < 4; i++) begin
      tick(); chk("t3_div0", filt_strobe, 1);
    end

    // External strobe mode
    mode = 1'b0;
    tick(); chk("t4_mode_sw", filt_strobe, 0);
    strobe_ext = 1'b1;
    tick(); chk("t4_ext_a", filt_strobe, 1);
    tick(); chk("t4_ext_b", filt_strobe, 1);
    strobe_ext = 1'b0;
    tick(); chk("t4_ext_off", filt_strobe, 0);
    sel = 2'd1; strobe_ext = 1'b1;
    tick(); chk("t4_flush", flush, 1); chk("t4_flush_filt", filt_strobe, 0); chk("t4_sel", sel_q, 1);
    tick(); chk("t4_after_flush_filt", filt_strobe, 0); chk("t4_warm", warm, 1);
    tick(); chk("t4_warm_filt", filt_strobe, 1);
    strobe_ext = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ret(10'h3C0); seen = seen | valid;
    end
    chk("t4_dropped4", seen, 0); chk("t4_run", warm, 0);
    ret(10'h0F0); chk("t4_valid", valid, 1); chk("t4_data", data, 10'h0F0);

    // Disable in RUN, then re-enable
    ena = 1'b0; strobe_ext = 1'b1; ret_strobe = 1'b1; ret_data = 10'h1E1;
    tick();
    chk("t5_off_warm", warm, 0); chk("t5_off_flush", flush, 0);
    chk("t5_off_filt", filt_strobe, 0); chk("t5_off_valid", valid, 0);
    chk("t5_off_data", data, 10'h0F0);
    ret_strobe = 1'b0; strobe_ext = 1'b0; ena = 1'b1;
    tick(); chk("t5_flush", flush, 1);
    tick(); chk("t5_warm", warm, 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ret(10'h005); seen = seen | valid;
    end
    chk("t5_dropped4", seen, 0); chk("t5_run", warm, 0);
    ret(10'h011); chk("t5_valid", valid, 1); chk("t5_data", data, 10'h011);

    // Asynchronous reset mid-warm-up
    sel = 2'd2;
    tick(); tick(); chk("t6_warm", warm, 1);
    ret(10'h077); chk("t6_still_warm", warm, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_warm", warm, 0);   chk("t6_rst_flush", flush, 0);
    chk("t6_rst_filt", filt_strobe, 0); chk("t6_rst_valid", valid, 0);
    chk("t6_rst_data", data, 0);   chk("t6_rst_sel", sel_q, 0);
    tick();
    rst_n = 1'b1;
    tick(); chk("t6_flush", flush, 1); chk("t6_sel", sel_q, 2);
    tick(); chk("t6_warm2", warm, 1);
    sel = 2'd0;
    ret(10'h3FF);
    chk("t6_chg_flush", flush, 1); chk("t6_chg_valid", valid, 0);
    chk("t6_chg_sel", sel_q, 0);   chk("t6_chg_data", data, 0);
    tick(); chk("t6_chg_warm", warm, 1);
    ret(10'h0AA); ret(10'h0BB); chk("t6_run", warm, 0);
    ret(10'h101); chk("t6_valid", valid, 1); chk("t6_data", data, 10'h101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
